// File: rtl/conv_out_packer.sv
// conv_out_packer
// Packs a no-backpressure stream of PIX_W-bit pixels into PIX_W*PACK-bit words
// (first pixel of a word in the LSBs). Completed words go into a
// first-word-fall-through FIFO that a valid/ready consumer drains. Frame
// position is tracked so that the word holding the last pixel of a frame is
// tagged with out_last. If the FIFO is full when a word completes and nothing
// is popped, the word is lost and a sticky overflow flag is raised.
//
// Ports
//   clk, rstn        : clock and synchronous active-low reset
//   valid_in, px_in  : incoming pixel stream (always accepted)
//   frame_start      : restart lane and frame counting; FIFO is untouched
//   out_valid/ready  : handshake for the packed output word
//   out_data/last    : FIFO head word and its end-of-frame tag
//   overflow         : sticky dropped-word flag, cleared by clr_overflow
//   frame_done       : one-cycle pulse after the final pixel of a frame
//   fifo_level       : current FIFO occupancy in words
module conv_out_packer #(
  parameter int PIX_W      = 8,
  parameter int PACK       = 4,
  parameter int FRAME_PIX  = 3844,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          valid_in,
  input  logic [PIX_W-1:0]              px_in,
  input  logic                          frame_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIX_W*PACK-1:0]         out_data,
  output logic                          out_last,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int WORD_W = PIX_W * PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FRM_W  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = AW + 1;

  logic [LANE_W-1:0] lane_cnt, lane_eff;
  logic [WORD_W-1:0] lane_data, lane_base, word_next;
  logic [FRM_W-1:0]  frame_cnt, frame_eff;
  logic              word_done, frame_end;
  logic              pop, full, accept, drop;

  logic [WORD_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WORD_W:0]   head;

  // frame_start acts as if the counters were already zero this cycle, so a
  // pixel arriving together with it becomes lane 0 / frame pixel 0.
  always_comb begin
    lane_eff  = frame_start ? '0 : lane_cnt;
    frame_eff = frame_start ? '0 : frame_cnt;
    lane_base = frame_start ? '0 : lane_data;
    word_next = lane_base;
    word_next[lane_eff*PIX_W +: PIX_W] = px_in;
    word_done = valid_in && (lane_eff == LANE_W'(PACK - 1));
    frame_end = valid_in && (frame_eff == FRM_W'(FRAME_PIX - 1));
    pop       = out_valid && out_ready;
    full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a full FIFO can still take a push.
    accept    = word_done && (!full || pop);
    drop      = word_done && full && !pop;
  end

  // Lane assembly, frame position, frame_done pulse and overflow flag.
  // Dropped words still advance every counter so framing stays aligned.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane_cnt   <= '0;
      lane_data  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (valid_in) begin
        if (word_done) begin
          lane_cnt  <= '0;
          lane_data <= '0;
        end else begin
          lane_cnt  <= lane_eff + 1'b1;
          lane_data <= word_next;
        end
        frame_cnt <= frame_end ? '0 : frame_eff + 1'b1;
      end else begin
        lane_cnt  <= lane_eff;
        lane_data <= lane_base;
        frame_cnt <= frame_eff;
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  // FIFO storage. Contents need no reset because the pointers and level
  // flush it; each entry carries the end-of-frame tag above the data.
  always_ff @(posedge clk) begin
    if (rstn && accept)
      mem[wr_ptr] <= {frame_end, word_next};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Fall-through head: outputs read zero whenever the FIFO is empty, which
  // also gives all-zero outputs straight after reset.
  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? head[WORD_W-1:0] : '0;
  assign out_last  = out_valid & head[WORD_W];

endmodule

// File: doc/conv_out_packer.md
CONV_OUT_PACKER -- requirements
Module: conv_out_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning input pixel width in bits.
REQ-002 SHALL have parameter PACK, default 4, meaning pixels per output word; output word width is PIX_W*PACK.
REQ-003 SHALL have parameter FRAME_PIX, default 3844, meaning pixels per frame; must be a nonzero multiple of PACK.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO depth in words; must be a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit, meaning synchronous active-low reset.
REQ-007 SHALL have port valid_in, input, 1 bit, meaning px_in is valid this cycle; it has no backpressure.
REQ-008 SHALL have port px_in, input, PIX_W bits, meaning an unsigned processed pixel from the convolution output stream.
REQ-009 SHALL have port frame_start, input, 1 bit, meaning a one-cycle pulse that restarts frame counting.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the FIFO head word is presented.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port out_data, output, PIX_W*PACK bits, meaning the packed word at the FIFO head.
REQ-013 SHALL have port out_last, output, 1 bit, meaning out_data is the final word of a frame.
REQ-014 SHALL have port overflow, output, 1 bit, meaning sticky flag set when a completed word was dropped.
REQ-015 SHALL have port clr_overflow, input, 1 bit, meaning clear overflow.
REQ-016 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse when the FRAME_PIX-th pixel of a frame is accepted.
REQ-017 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, meaning the current FIFO occupancy in words.

Function
REQ-018 SHALL accept px_in on every cycle where valid_in=1, without stalling.
REQ-019 SHALL place the k-th accepted pixel of a word (k=0..PACK-1) in bits [k*PIX_W +: PIX_W] of the word, with pixel 0 at the LSBs.
REQ-020 SHALL push the completed word into the FIFO on the same edge that accepts pixel PACK-1; the lane register and lane counter then return to 0.
REQ-021 SHALL keep a frame pixel counter 0..FRAME_PIX-1 that increments per accepted pixel and wraps to 0 after FRAME_PIX-1.
REQ-022 SHALL tag the pushed word with last=1 exactly when it contains pixel FRAME_PIX-1, and assert frame_done for one cycle on the following cycle.
REQ-023 SHALL make the FIFO first-word-fall-through: out_valid rises in the cycle after the push edge when the FIFO was empty, so push-to-out_valid latency is 1 cycle.
REQ-024 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL accept a push when the FIFO is full if a pop occurs in the same cycle, leaving the level unchanged.
REQ-026 SHALL drop a completed word when the FIFO is full and no pop occurs, set overflow, and still advance the lane and frame counters and still pulse frame_done.
REQ-027 SHALL give set priority over clear: when a drop and clr_overflow occur together, overflow remains 1.
REQ-028 SHALL, on frame_start, discard any partial lane data and zero the lane and frame counters without affecting FIFO contents.
REQ-029 SHALL, when frame_start and valid_in occur together, treat that pixel as pixel 0 of the new frame.
REQ-030 SHALL make fifo_level equal pushes minus pops, range 0..FIFO_DEPTH, with out_valid = (fifo_level != 0).

Reset
REQ-031 SHALL, while rstn=0 at a clock edge, clear out_valid, out_last, out_data, overflow, frame_done, fifo_level, the lane counter and the frame counter to 0, and flush the FIFO.
REQ-032 SHALL, when reset is applied mid-frame, discard the partial word and all FIFO contents; the first pixel after rstn=1 is lane 0, frame pixel 0.

Verification
REQ-033 SHALL be checked by this scenario: pixels 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> out_data=0x44332211 and out_valid=1 one cycle after the 4th pixel, with out_last=0.
REQ-034 SHALL be checked by this scenario: a full frame of 3844 pixels with out_ready=1 -> exactly 961 words, out_last only on word 961, and one frame_done pulse.
REQ-035 SHALL be checked by this scenario: out_ready=0 while 68 pixels stream in -> fifo_level=16, overflow=1, one word dropped; then out_ready=1 -> 16 words drain in order, bit-exact.
REQ-036 SHALL be checked by this scenario: FIFO full with out_ready=1 during a push cycle -> no drop, fifo_level stays 16, overflow stays 0.
REQ-037 SHALL be checked by this scenario: 2 pixels, then frame_start, then 0xAA,0xBB,0xCC,0xDD -> a single word 0xDDCCBBAA, with the first 2 pixels never output.
REQ-038 SHALL be checked by this scenario: rstn=0 for one cycle with 3 words queued and a partial lane -> all outputs 0 next cycle, and the subsequent 4 pixels form the first word.
